weight_fill_scheduler: RTL

Sequences the transfer of one or more weight tiles from weight memory into the per-column weight FIFOs ahead of the systolic array. On a `start` command it walks `num_tiles` tiles of `WIDTH_HEIGHT` rows each from `base_addr`, and waits on FIFO back-pressure between tiles. It drives the weight-memory read ports and produces per-lane FIFO write strobes aligned to the 1-cycle memory read latency. It sits between the top-level controller and the weight memory / weight FIFO pair.

---
 rtl/weight_fill_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/weight_fill_scheduler.sv
// Weight-tile fill sequencer: walks num_tiles tiles of WIDTH_HEIGHT rows into the weight FIFOs.
// Optional diagonal-skewed fill is enabled by defining WEIGHT_FILL_SKEW_EN.
module weight_fill_scheduler #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int ADDR_W       = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [3:0]                     num_tiles,
    input  logic                           abort,
    input  logic                           fifo_ready,
    output logic                           busy,
    output logic                           done,
    output logic [3:0]                     tile_idx,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] weightMem_rd_addr,
    output logic [WIDTH_HEIGHT-1:0]        weightMem_rd_en,
    output logic [WIDTH_HEIGHT-1:0]        mem_to_fifo,
    output logic [2:0]                     dbg_state
);

`ifdef WEIGHT_FILL_SKEW_EN
    localparam int FILL_ROWS = 2*WIDTH_HEIGHT - 1;
`else
    localparam int FILL_ROWS = WIDTH_HEIGHT;
`endif
    localparam int ROW_W = $clog2(2*WIDTH_HEIGHT);

    typedef enum logic [2:0] {IDLE, WAIT_FIFO, FILL, DRAIN, DONE} state_t;

    state_t                         state, state_n;
    logic [ROW_W-1:0]               row, row_n;
    logic [3:0]                     tile_n;
    logic [ADDR_W-1:0]              base_q, base_n;
    logic [3:0]                     tiles_q, tiles_n;
    logic [ADDR_W-1:0]              tile_base;
    logic [WIDTH_HEIGHT-1:0]        en_n;
    logic [WIDTH_HEIGHT*ADDR_W-1:0] addr_n;

    assign dbg_state = state;

    always_comb begin
        state_n = state;
        row_n   = row;
        tile_n  = tile_idx;
        base_n  = base_q;
        tiles_n = tiles_q;
        case (state)
            IDLE: begin
                if (start) begin
                    base_n  = base_addr;
                    tiles_n = num_tiles;
                    tile_n  = '0;
                    state_n = (num_tiles == 4'd0) ? DONE : WAIT_FIFO;
                end
            end
            WAIT_FIFO: begin
                row_n = '0;
                if (fifo_ready) state_n = FILL;
            end
            FILL: begin
                if (row == ROW_W'(FILL_ROWS-1)) begin
                    state_n = DRAIN;
                    row_n   = '0;
                end else begin
                    row_n = row + 1'b1;
                end
            end
            DRAIN: begin
                tile_n  = tile_idx + 4'd1;
                state_n = (tile_n == tiles_q) ? DONE : WAIT_FIFO;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Abort overrides every transition, including DRAIN -> DONE.
        if (state != IDLE && abort) begin
            state_n = IDLE;
            tile_n  = '0;
            row_n   = '0;
        end
    end

    // Read enables/addresses are computed for the next cycle so they leave a flop.
    always_comb begin
        tile_base = base_q + ADDR_W'(int'(tile_n) * WIDTH_HEIGHT);
        en_n      = '0;
        addr_n    = weightMem_rd_addr;
        for (int i = 0; i < WIDTH_HEIGHT; i++) begin
`ifdef WEIGHT_FILL_SKEW_EN
            if (state_n == FILL && int'(row_n) >= i && (int'(row_n) - i) < WIDTH_HEIGHT) begin
                en_n[i] = 1'b1;
                addr_n[i*ADDR_W +: ADDR_W] = tile_base + ADDR_W'(int'(row_n) - i);
            end
`else
            if (state_n == FILL) begin
                en_n[i] = 1'b1;
                addr_n[i*ADDR_W +: ADDR_W] = tile_base + ADDR_W'(row_n);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            row               <= '0;
            base_q            <= '0;
            tiles_q           <= '0;
            tile_idx          <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            weightMem_rd_addr <= '0;
            weightMem_rd_en   <= '0;
            mem_to_fifo       <= '0;
        end else begin
            state             <= state_n;
            row               <= row_n;
            base_q            <= base_n;
            tiles_q           <= tiles_n;
            tile_idx          <= tile_n;
            busy              <= (state_n != IDLE);
            done              <= (state_n == DONE);
            weightMem_rd_addr <= addr_n;
            weightMem_rd_en   <= en_n;
            mem_to_fifo       <= weightMem_rd_en;
        end
    end

endmodule
